hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the RV32I core, generalising the fixed 3-stage, always-enabled pipeline registers to an N-stage pipeline with stall, flush and forwarding. It sits beside the `controller`. It keeps a scoreboard of in-flight destination registers, drives operand-forwarding selects, and handles load-use stalls, branch flushes and variable-latency data-memory waits. It also raises a sticky error on a data-memory timeout and counts stall and flush cycles.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/control unit: scoreboard entry layout,
// control FSM states and the forwarding-select encoding.
package hazard_pkg;

    // Scoreboard rd field is sized for the widest supported register index;
    // narrower indices are zero-extended on entry and on compare.
    localparam int SB_RD_W = 8;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_wr;
        logic               is_load;
        logic               is_mem;
    } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, used for the
// stall and flush performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// N-stage pipeline control: in-flight destination scoreboard, operand
// forwarding selects, load-use stalls, branch flushes and dmem wait/timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int NUM_STAGES      = 3,
    parameter  int MEM_STAGE       = 1,
    parameter  int REG_INDEX_WIDTH = 5,
    parameter  int MEM_TIMEOUT     = 15,
    parameter  int CNT_WIDTH       = 32,
    localparam int FWD_W           = $clog2(NUM_STAGES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dec_valid,
    input  logic [REG_INDEX_WIDTH-1:0] dec_rs1,
    input  logic [REG_INDEX_WIDTH-1:0] dec_rs2,
    input  logic                       dec_rs1_used,
    input  logic                       dec_rs2_used,
    input  logic [REG_INDEX_WIDTH-1:0] dec_rd,
    input  logic                       dec_reg_wr,
    input  logic                       dec_is_load,
    input  logic                       dec_is_mem,
    input  logic                       br_taken,
    input  logic                       mem_ready,
    output logic                       pipe_en,
    output logic                       stall_FD,
    output logic                       flush_FD,
    output logic                       issue,
    output logic [FWD_W-1:0]           fwd_a,
    output logic [FWD_W-1:0]           fwd_b,
    output logic                       mem_err,
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt
);

    localparam int LAST   = NUM_STAGES - 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // The detecting RUN cycle and the first WAIT cycle are wait cycles 1 and 2,
    // so the timeout fires when the WAIT count reaches MEM_TIMEOUT-2.
    localparam int TIMEOUT_LAST = MEM_TIMEOUT - 2;

    sb_entry_t          sb [1:LAST];
    sb_entry_t          new_entry;
    hz_state_e          state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               kill_q;
    logic               dmem_hold;
    logic               mem_hold;
    logic               dec_live;
    logic               hazard;

    function automatic logic [FWD_W-1:0] youngest_match(
        input sb_entry_t                  tbl [1:LAST],
        input logic [REG_INDEX_WIDTH-1:0] src,
        input logic                       used
    );
        logic [FWD_W-1:0] idx;
        idx = FWD_W'(FWD_REGFILE);
        for (int k = LAST; k >= 1; k--) begin
            if (used && tbl[k].valid && tbl[k].reg_wr && (tbl[k].rd != '0) &&
                (tbl[k].rd == SB_RD_W'(src))) begin
                idx = FWD_W'(k);
            end
        end
        return idx;
    endfunction

    // A load still at or before the memory stage cannot supply its data yet.
    function automatic logic load_not_ready(
        input sb_entry_t        tbl [1:LAST],
        input logic [FWD_W-1:0] idx
    );
        logic pending;
        pending = 1'b0;
        for (int k = 1; k <= LAST; k++) begin
            if ((int'(idx) == k) && (k <= MEM_STAGE)) begin
                pending = tbl[k].is_load;
            end
        end
        return pending;
    endfunction

    assign fwd_a = youngest_match(sb, dec_rs1, dec_rs1_used);
    assign fwd_b = youngest_match(sb, dec_rs2, dec_rs2_used);

    assign dec_live  = dec_valid & ~kill_q;
    assign hazard    = dec_live & (load_not_ready(sb, fwd_a) | load_not_ready(sb, fwd_b));
    assign dmem_hold = sb[MEM_STAGE].valid & sb[MEM_STAGE].is_mem & ~mem_ready;
    assign mem_hold  = dmem_hold | (state == ERR);

    assign pipe_en  = ~mem_hold;
    assign issue    = dec_live & ~hazard & ~mem_hold;
    assign stall_FD = (hazard | mem_hold) & ~kill_q;
    assign flush_FD = br_taken & issue;
    assign mem_err  = (state == ERR);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = SB_RD_W'(dec_rd);
            new_entry.reg_wr  = dec_reg_wr;
            new_entry.is_load = dec_is_load;
            new_entry.is_mem  = dec_is_mem;
        end
    end

    // NOTE: the scoreboard is a few flops, so whole entries are reset rather
    // than only the valid bits; payload never leaks X into the compares.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= LAST; k++) begin
                sb[k] <= '0;
            end
        end else if (pipe_en) begin
            for (int k = LAST; k >= 2; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[1] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kill_q   <= 1'b0;
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            kill_q <= flush_FD;
            case (state)
                RUN: begin
                    if (dmem_hold) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT_LAST)) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_FD),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_FD),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (NUM_STAGES=3, MEM_STAGE=1, MEM_TIMEOUT=15):
// forwarding, load-use, x0, branch flush, dmem wait and timeout.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd;
    logic        dec_reg_wr;
    logic        dec_is_load;
    logic        dec_is_mem;
    logic        br_taken;
    logic        mem_ready;
    logic        pipe_en;
    logic        stall_FD;
    logic        flush_FD;
    logic        issue;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_stall   = 0;
    int exp_flush   = 0;

    hazard_ctrl #(
        .NUM_STAGES      (3),
        .MEM_STAGE       (1),
        .REG_INDEX_WIDTH (5),
        .MEM_TIMEOUT     (15),
        .CNT_WIDTH       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_reg_wr   (dec_reg_wr),
        .dec_is_load  (dec_is_load),
        .dec_is_mem   (dec_is_mem),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .pipe_en      (pipe_en),
        .stall_FD     (stall_FD),
        .flush_FD     (flush_FD),
        .issue        (issue),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Applies one decode slot at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic mem,
                         input logic br, input logic rdy);
        @(negedge clk);
        dec_valid    = v;
        dec_rs1      = rs1;
        dec_rs1_used = u1;
        dec_rs2      = rs2;
        dec_rs2_used = u2;
        dec_rd       = rd;
        dec_reg_wr   = wr;
        dec_is_load  = ld;
        dec_is_mem   = mem;
        br_taken     = br;
        mem_ready    = rdy;
        #1;
    endtask

    task automatic drain();
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dec_valid = 1'b1; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_reg_wr = 0; dec_is_load = 0; dec_is_mem = 0;
        br_taken = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vectors++; if (pipe_en !== 1'b1) begin miscompares++; $display("FAIL rst.pipe_en got=%b want=1", pipe_en); end
        vectors++; if (stall_FD !== 1'b0) begin miscompares++; $display("FAIL rst.stall_FD got=%b want=0", stall_FD); end
        vectors++; if (flush_FD !== 1'b0) begin miscompares++; $display("FAIL rst.flush_FD got=%b want=0", flush_FD); end
        vectors++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin miscompares++; $display("FAIL rst.fwd got=%0d/%0d want=0/0", fwd_a, fwd_b); end
        vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rst.mem_err got=%b want=0", mem_err); end
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL rst.issue got=%b want=1", issue); end
        vectors++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin miscompares++; $display("FAIL rst.cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        drain();
    endtask

    task automatic test_forward();
        drive(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 1);            // addi x5, x0, imm
        vectors++; if (issue !== 1'b1 || fwd_a !== 2'd0) begin miscompares++; $display("FAIL fwd.addi issue/fwd_a got=%b/%0d want=1/0", issue, fwd_a); end
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 1);            // add x6, x5, x5
        vectors++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin miscompares++; $display("FAIL fwd.add fwd got=%0d/%0d want=1/1", fwd_a, fwd_b); end
        vectors++; if (stall_FD !== 1'b0 || issue !== 1'b1) begin miscompares++; $display("FAIL fwd.add stall/issue got=%b/%b want=0/1", stall_FD, issue); end
        drive(1, 5, 1, 0, 1, 9, 1, 0, 0, 0, 1);            // sub x9, x5, x0
        vectors++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin miscompares++; $display("FAIL fwd.sub fwd got=%0d/%0d want=2/0", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1, 0, 1, 0, 0, 7, 1, 1, 1, 0, 1);            // lw x7
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL lu.lw issue got=%b want=1", issue); end
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 1);            // add x8, x7, x0
        vectors++; if (stall_FD !== 1'b1 || issue !== 1'b0) begin miscompares++; $display("FAIL lu.stall stall/issue got=%b/%b want=1/0", stall_FD, issue); end
        vectors++; if (pipe_en !== 1'b1 || fwd_a !== 2'd1) begin miscompares++; $display("FAIL lu.stall pipe_en/fwd_a got=%b/%0d want=1/1", pipe_en, fwd_a); end
        exp_stall++;
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 1);
        vectors++; if (stall_FD !== 1'b0 || issue !== 1'b1 || fwd_a !== 2'd2) begin miscompares++; $display("FAIL lu.go stall/issue/fwd_a got=%b/%b/%0d want=0/1/2", stall_FD, issue, fwd_a); end
        vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL lu.stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_x0();
        drive(1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1);            // lw x0
        drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 1);            // add x3, x0, x0
        vectors++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin miscompares++; $display("FAIL x0.fwd got=%0d/%0d want=0/0", fwd_a, fwd_b); end
        vectors++; if (stall_FD !== 1'b0 || issue !== 1'b1) begin miscompares++; $display("FAIL x0.stall/issue got=%b/%b want=0/1", stall_FD, issue); end
        drain();
    endtask

    task automatic test_branch();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 1);           // taken branch issuing
        vectors++; if (issue !== 1'b1 || flush_FD !== 1'b1) begin miscompares++; $display("FAIL br.flush issue/flush got=%b/%b want=1/1", issue, flush_FD); end
        exp_flush++;
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1);           // wrong-path slot
        vectors++; if (issue !== 1'b0 || flush_FD !== 1'b0 || stall_FD !== 1'b0) begin miscompares++; $display("FAIL br.kill issue/flush/stall got=%b/%b/%b want=0/0/0", issue, flush_FD, stall_FD); end
        vectors++; if (flush_cnt !== 32'(exp_flush)) begin miscompares++; $display("FAIL br.flush_cnt got=%0d want=%0d", flush_cnt, exp_flush); end
        drive(1, 11, 1, 10, 1, 12, 1, 0, 0, 0, 1);         // x11 was killed, x10 at entry 2
        vectors++; if (issue !== 1'b1 || fwd_a !== 2'd0 || fwd_b !== 2'd2) begin miscompares++; $display("FAIL br.after issue/fwd got=%b/%0d/%0d want=1/0/2", issue, fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_hazard_branch();
        drive(1, 0, 1, 0, 0, 12, 1, 1, 1, 0, 1);           // lw x12
        drive(1, 12, 1, 0, 0, 13, 0, 0, 0, 1, 1);          // branch on x12
        vectors++; if (issue !== 1'b0 || flush_FD !== 1'b0 || stall_FD !== 1'b1) begin miscompares++; $display("FAIL hb.hold issue/flush/stall got=%b/%b/%b want=0/0/1", issue, flush_FD, stall_FD); end
        exp_stall++;
        drive(1, 12, 1, 0, 0, 13, 0, 0, 0, 1, 1);
        vectors++; if (issue !== 1'b1 || flush_FD !== 1'b1 || stall_FD !== 1'b0) begin miscompares++; $display("FAIL hb.go issue/flush/stall got=%b/%b/%b want=1/1/0", issue, flush_FD, stall_FD); end
        exp_flush++;
        drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 1);
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL hb.kill issue got=%b want=0", issue); end
        vectors++; if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin miscompares++; $display("FAIL hb.cnt got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); end
        drain();
    endtask

    task automatic test_mem_wait();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);            // sw
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0);
            vectors++; if (pipe_en !== 1'b0 || stall_FD !== 1'b1 || issue !== 1'b0 || mem_err !== 1'b0) begin
                miscompares++; $display("FAIL mw.wait%0d pe/stall/issue/err got=%b/%b/%b/%b want=0/1/0/0", i, pipe_en, stall_FD, issue, mem_err);
            end
            exp_stall++;
        end
        drive(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1);
        vectors++; if (pipe_en !== 1'b1 || stall_FD !== 1'b0 || issue !== 1'b1) begin miscompares++; $display("FAIL mw.resume pe/stall/issue got=%b/%b/%b want=1/0/1", pipe_en, stall_FD, issue); end
        vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL mw.stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_timeout();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);            // sw
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0);
            vectors++; if (mem_err !== (i == 16) || pipe_en !== 1'b0) begin
                miscompares++; $display("FAIL to.cyc%0d err/pe got=%b/%b want=%b/0", i, mem_err, pipe_en, (i == 16));
            end
            exp_stall++;
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 1);
            vectors++; if (mem_err !== 1'b1 || pipe_en !== 1'b0 || stall_FD !== 1'b1 || issue !== 1'b0) begin
                miscompares++; $display("FAIL to.sticky%0d err/pe/stall/issue got=%b/%b/%b/%b want=1/0/1/0", i, mem_err, pipe_en, stall_FD, issue);
            end
            vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL to.stall_cnt%0d got=%0d want=%0d", i, stall_cnt, exp_stall); end
            exp_stall++;
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        exp_stall = 0;
        exp_flush = 0;
        vectors++; if (mem_err !== 1'b0 || pipe_en !== 1'b1) begin miscompares++; $display("FAIL to.reset err/pe got=%b/%b want=0/1", mem_err, pipe_en); end
        vectors++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin miscompares++; $display("FAIL to.reset cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 1);
        vectors++; if (issue !== 1'b1 || stall_FD !== 1'b0) begin miscompares++; $display("FAIL to.run issue/stall got=%b/%b want=1/0", issue, stall_FD); end
        drain();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_branch();
        test_hazard_branch();
        test_mem_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
